sim_step_controller: RTL and testbench
======================================

Name: sim_step_controller

Overview:
Run-control sequencer for the circuit-simulator datapath: the NOT-gate/logic network and its 1/16/32/16/16-bit result buses.
- On a start command it clears the datapath, then issues exactly N single-cycle step enables, each followed by a settle window.
- After the last settle window it snapshots all five result buses into capture registers and pulses done.
- Sits between the board-level command/UART logic and the simulated circuit, so host reads always see a stable, coherent result set.

Parameters:
SETTLE_CYCLES, 2, idle cycles after each sim_en pulse before the next step or capture (0 allowed).
STEP_W, 16, width of step_count and steps_done.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  run request; sampled only in IDLE
abort  input  1  cancel current run; wins over every other event
step_count  input  STEP_W  number of steps N; latched on accepted start
sim_clear  output  1  one-cycle clear pulse to the datapath
sim_en  output  1  one-cycle step enable to the datapath
sim_out1  input  1  datapath result bus 1
sim_out2  input  16  datapath result bus 2
sim_out3  input  32  datapath result bus 3
sim_out4  input  16  datapath result bus 4
sim_out5  input  16  datapath result bus 5
cap1  output  1  captured sim_out1
cap2  output  16  captured sim_out2
cap3  output  32  captured sim_out3
cap4  output  16  captured sim_out4
cap5  output  16  captured sim_out5
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, coincident with cap* update
aborted  output  1  one-cycle pulse after an abort
steps_done  output  STEP_W  sim_en pulses issued in current/last run

Behaviour:
- Reset (async): state=IDLE; sim_clear, sim_en, busy, done, aborted = 0; steps_done = 0; cap1..cap5 = 0.
- All outputs are registered.
- States: IDLE, CLEAR, STEP, SETTLE.
- IDLE, start=1 at edge e: latch N, steps_done<=0, go to CLEAR. Cycle e+1 has sim_clear=1 and busy=1.
- CLEAR -> STEP if N>0; else capture directly (see capture rule) and return to IDLE.
- STEP: sim_en=1 for exactly one cycle; steps_done increments on the same edge sim_en rises.
- STEP -> SETTLE for SETTLE_CYCLES cycles (skipped when 0), then:
  - STEP again if steps_done<N;
  - otherwise capture.
- Capture: on the edge leaving the final settle (or CLEAR when N=0), cap1..cap5 <= sim_out1..5, done=1 for one cycle, state -> IDLE, busy=0 in that same cycle.
- Timing: sim_en is high in cycles e+2+i*(1+SETTLE_CYCLES), for i=0..N-1. done is high in cycle e+2+N*(1+SETTLE_CYCLES).
- start while busy: ignored, no queuing. start in the done cycle is accepted (state is IDLE).
- step_count changes while busy: ignored; the latched N is used.
- abort=1 in any busy state:
  - next cycle: state=IDLE, sim_en=0, sim_clear=0, aborted=1, done=0;
  - cap* hold their previous values; steps_done holds the count reached.
- abort in IDLE: no effect, no aborted pulse.
- abort and start at the same edge in IDLE: abort wins; start is dropped.
- N = 2^STEP_W-1: runs fully; steps_done never wraps.
- Reset mid-run: immediate return to reset values; no done or aborted pulse.

Test Plan:
- Reset asserted mid-run with sim_en high -> all outputs 0 asynchronously, before the next clock edge; after release, state IDLE and start accepted.
- SETTLE_CYCLES=2, N=3, start at edge 0 -> sim_clear in cycle 1; sim_en in cycles 2, 5, 8; done in cycle 11 with cap3 equal to sim_out3 at edge 10; steps_done=3.
- N=0, SETTLE_CYCLES=2 -> sim_clear in cycle 1, no sim_en, done in cycle 2, busy low from cycle 2.
- start held high for the whole run, N=2, SETTLE_CYCLES=0 -> exactly one run (sim_en cycles 2, 3; done cycle 4); a second run starts with sim_clear in cycle 5.
- abort asserted in the cycle after the 2nd sim_en, N=5 -> aborted pulse next cycle; steps_done=2; no done; cap* unchanged from the prior run.
- abort and start at the same edge in IDLE -> no sim_clear, no aborted, busy stays 0.

Source files
------------

// File: rtl/sim_step_controller.sv
// Run-control sequencer for the simulated logic network: clear, N stepped enables with
// settle windows, then a coherent snapshot of all five result buses.
module sim_step_controller #(
    parameter int SETTLE_CYCLES = 2,
    parameter int STEP_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] step_count,
    output logic              sim_clear,
    output logic              sim_en,
    input  logic              sim_out1,
    input  logic [15:0]       sim_out2,
    input  logic [31:0]       sim_out3,
    input  logic [15:0]       sim_out4,
    input  logic [15:0]       sim_out5,
    output logic              cap1,
    output logic [15:0]       cap2,
    output logic [31:0]       cap3,
    output logic [15:0]       cap4,
    output logic [15:0]       cap5,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_done
);

    typedef enum logic [1:0] {IDLE, CLEAR, STEP, SETTLE} state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    state_t            state, state_next;
    logic [CNT_W-1:0]  settle_cnt, settle_cnt_next;
    logic [STEP_W-1:0] n_q;
    logic              fire, capture, abort_now;
    logic              more_steps;

    assign more_steps = (steps_done < n_q);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        fire            = 1'b0;
        capture         = 1'b0;
        abort_now       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) state_next = CLEAR;
            end
            CLEAR: begin
                if (n_q != '0) begin
                    state_next = STEP;
                    fire       = 1'b1;
                end else begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end
            end
            STEP: begin
                if (SETTLE_CYCLES > 0) begin
                    state_next      = SETTLE;
                    settle_cnt_next = SETTLE_LAST;
                end else if (more_steps) begin
                    fire = 1'b1;
                end else begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt != '0) begin
                    settle_cnt_next = settle_cnt - 1'b1;
                end else if (more_steps) begin
                    state_next = STEP;
                    fire       = 1'b1;
                end else begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides stepping and capture alike.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            fire       = 1'b0;
            capture    = 1'b0;
            abort_now  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    // Outputs are registered from next-state decisions so they align with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sim_clear  <= 1'b0;
            sim_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            steps_done <= '0;
            n_q        <= '0;
            cap1       <= 1'b0;
            cap2       <= '0;
            cap3       <= '0;
            cap4       <= '0;
            cap5       <= '0;
        end else begin
            sim_clear <= (state_next == CLEAR);
            sim_en    <= fire;
            busy      <= (state_next != IDLE);
            done      <= capture;
            aborted   <= abort_now;
            if (state == IDLE && state_next == CLEAR) begin
                n_q        <= step_count;
                steps_done <= '0;
            end else if (fire) begin
                steps_done <= steps_done + STEP_W'(1);
            end
            if (capture) begin
                cap1 <= sim_out1;
                cap2 <= sim_out2;
                cap3 <= sim_out3;
                cap4 <= sim_out4;
                cap5 <= sim_out5;
            end
        end
    end

endmodule

// File: tb/tb_sim_step_controller.sv
// Self-checking bench for sim_step_controller: a per-cycle vector table on a SETTLE_CYCLES=2
// instance, plus hand sequences on a SETTLE_CYCLES=0, 4-bit instance and a mid-run reset.
module tb_sim_step_controller;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        sim_out1;
    logic [15:0] sim_out2, sim_out4, sim_out5;
    logic [31:0] sim_out3;

    // Instance A: SETTLE_CYCLES=2, STEP_W=16
    logic        a_start, a_abort, a_clear, a_en, a_busy, a_done, a_aborted, a_cap1;
    logic [15:0] a_n, a_steps, a_cap2, a_cap4, a_cap5;
    logic [31:0] a_cap3;

    // Instance B: SETTLE_CYCLES=0, STEP_W=4
    logic        b_start, b_abort, b_clear, b_en, b_busy, b_done, b_aborted, b_cap1;
    logic [3:0]  b_n, b_steps;
    logic [15:0] b_cap2, b_cap4, b_cap5;
    logic [31:0] b_cap3;

    sim_step_controller #(.SETTLE_CYCLES(2), .STEP_W(16)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .abort(a_abort), .step_count(a_n),
        .sim_clear(a_clear), .sim_en(a_en),
        .sim_out1(sim_out1), .sim_out2(sim_out2), .sim_out3(sim_out3),
        .sim_out4(sim_out4), .sim_out5(sim_out5),
        .cap1(a_cap1), .cap2(a_cap2), .cap3(a_cap3), .cap4(a_cap4), .cap5(a_cap5),
        .busy(a_busy), .done(a_done), .aborted(a_aborted), .steps_done(a_steps)
    );

    sim_step_controller #(.SETTLE_CYCLES(0), .STEP_W(4)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .abort(b_abort), .step_count(b_n),
        .sim_clear(b_clear), .sim_en(b_en),
        .sim_out1(sim_out1), .sim_out2(sim_out2), .sim_out3(sim_out3),
        .sim_out4(sim_out4), .sim_out5(sim_out5),
        .cap1(b_cap1), .cap2(b_cap2), .cap3(b_cap3), .cap4(b_cap4), .cap5(b_cap5),
        .busy(b_busy), .done(b_done), .aborted(b_aborted), .steps_done(b_steps)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Result-bus pattern for vector index k; a capture index of -1 means "still reset zero".
    function automatic logic [80:0] caps_of(input int idx);
        logic [31:0] k;
        if (idx < 0) return '0;
        k = idx;
        return {k[0], 16'h2000 + k[15:0], 32'h3000_0000 + k, 16'h4000 + k[15:0], 16'h5000 + k[15:0]};
    endfunction

    task automatic set_outs(input int idx);
        logic [80:0] v;
        v = caps_of(idx);
        {sim_out1, sim_out2, sim_out3, sim_out4, sim_out5} = v;
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic [15:0] n;
        logic        exp_clear;
        logic        exp_en;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_aborted;
        logic [15:0] exp_steps;
        int          cap_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic ab, input logic [15:0] n,
                       input logic cl, input logic en, input logic bz, input logic dn,
                       input logic at, input logic [15:0] st, input int ci);
        vec_t v;
        v.start = s; v.abort = ab; v.n = n;
        v.exp_clear = cl; v.exp_en = en; v.exp_busy = bz; v.exp_done = dn;
        v.exp_aborted = at; v.exp_steps = st; v.cap_idx = ci;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        int done_cyc;

        reset = 1'b1;
        a_start = 0; a_abort = 0; a_n = '0;
        b_start = 0; b_abort = 0; b_n = '0;
        set_outs(0);

        // Vector k: inputs applied before edge k; outputs checked just after edge k.
        // N=3 run (step_count changed mid-run, a stray start while busy)
        add(1,0,3,  1,0,1,0,0, 0,-1);
        add(0,0,7,  0,1,1,0,0, 1,-1);
        add(0,0,7,  0,0,1,0,0, 1,-1);
        add(0,0,7,  0,0,1,0,0, 1,-1);
        add(0,0,7,  0,1,1,0,0, 2,-1);
        add(1,0,7,  0,0,1,0,0, 2,-1);
        add(0,0,7,  0,0,1,0,0, 2,-1);
        add(0,0,7,  0,1,1,0,0, 3,-1);
        add(0,0,7,  0,0,1,0,0, 3,-1);
        add(0,0,7,  0,0,1,0,0, 3,-1);
        add(0,0,0,  0,0,0,1,0, 3,10);
        add(0,0,0,  0,0,0,0,0, 3,10);
        // N=0 run
        add(1,0,0,  1,0,1,0,0, 0,10);
        add(0,0,0,  0,0,0,1,0, 0,13);
        add(0,0,5,  0,0,0,0,0, 0,13);
        // N=5 run, abort after the second step
        add(1,0,5,  1,0,1,0,0, 0,13);
        add(0,0,5,  0,1,1,0,0, 1,13);
        add(0,0,5,  0,0,1,0,0, 1,13);
        add(0,0,5,  0,0,1,0,0, 1,13);
        add(0,0,5,  0,1,1,0,0, 2,13);
        add(0,1,5,  0,0,0,0,1, 2,13);
        add(0,0,5,  0,0,0,0,0, 2,13);
        // abort and start together in IDLE
        add(1,1,5,  0,0,0,0,0, 2,13);
        add(0,0,5,  0,0,0,0,0, 2,13);

        repeat (2) @(posedge clock);
        #1;
        check("reset_a_outputs", {a_clear, a_en, a_busy, a_done, a_aborted, a_steps}, '0);
        check("reset_a_caps", {a_cap1, a_cap2, a_cap3, a_cap4, a_cap5}, '0);
        check("reset_b_outputs", {b_clear, b_en, b_busy, b_done, b_aborted, b_steps}, '0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            a_start = vecs[i].start;
            a_abort = vecs[i].abort;
            a_n     = vecs[i].n;
            set_outs(i);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_clear", i), a_clear, vecs[i].exp_clear);
            check($sformatf("v%0d_en", i), a_en, vecs[i].exp_en);
            check($sformatf("v%0d_busy", i), a_busy, vecs[i].exp_busy);
            check($sformatf("v%0d_done", i), a_done, vecs[i].exp_done);
            check($sformatf("v%0d_aborted", i), a_aborted, vecs[i].exp_aborted);
            check($sformatf("v%0d_steps", i), a_steps, vecs[i].exp_steps);
            check($sformatf("v%0d_caps", i), {a_cap1, a_cap2, a_cap3, a_cap4, a_cap5},
                  caps_of(vecs[i].cap_idx));
        end
        a_start = 0; a_abort = 0;

        // Instance B: start held high, N=2, zero settle
        b_n = 4'd2;
        b_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock);
            #1;
            check($sformatf("held_c%0d_clear", c), b_clear, (c == 1 || c == 5));
            check($sformatf("held_c%0d_en", c), b_en, (c == 2 || c == 3));
            check($sformatf("held_c%0d_done", c), b_done, (c == 4));
        end
        b_start = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            #1;
            if (b_done) begin
                done_cyc = c;
                break;
            end
        end
        check("held_second_run_done", done_cyc, 3);

        // Instance B: maximum N for a 4-bit counter
        @(negedge clock);
        b_n = 4'd15;
        b_start = 1'b1;
        pulses = 0;
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            b_start = 1'b0;
            if (b_en) pulses++;
            if (b_done) begin
                done_cyc = c;
                break;
            end
        end
        check("maxn_pulses", pulses, 15);
        check("maxn_done_cycle", done_cyc, 17);
        check("maxn_steps_done", b_steps, 4'd15);
        check("maxn_busy_in_done", b_busy, 1'b0);

        // Instance A: asynchronous reset while sim_en is high
        @(negedge clock);
        a_n = 16'd3;
        a_start = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock);
            #1;
            a_start = 1'b0;
            if (a_en) begin
                pulses = 1;
                break;
            end
        end
        check("rst_pre_en", pulses, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_outputs", {a_clear, a_en, a_busy, a_done, a_aborted, a_steps}, '0);
        check("rst_async_caps", {a_cap1, a_cap2, a_cap3, a_cap4, a_cap5}, '0);
        @(negedge clock);
        reset = 1'b0;
        a_n = 16'd1;
        a_start = 1'b1;
        @(posedge clock);
        #1;
        a_start = 1'b0;
        check("rst_restart_clear", {a_clear, a_busy}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
